// File: rtl/muldiv_sequencer.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Long ops hold busy for a fixed latency and commit at the final busy edge; mthi/mtlo apply in one cycle.
module muldiv_sequencer #(
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        flush,
   input  logic        out_sel,
   output logic        busy,
   output logic        stall_req,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] result
);

   localparam logic [3:0] OP_DISABLED = 4'd0;
   localparam logic [3:0] OP_MULT     = 4'd1;
   localparam logic [3:0] OP_MULTU    = 4'd2;
   localparam logic [3:0] OP_DIV      = 4'd3;
   localparam logic [3:0] OP_DIVU     = 4'd4;
   localparam logic [3:0] OP_MADD     = 4'd5;
   localparam logic [3:0] OP_MADDU    = 4'd6;
   localparam logic [3:0] OP_MSUB     = 4'd7;
   localparam logic [3:0] OP_SETHI    = 4'd8;
   localparam logic [3:0] OP_SETLO    = 4'd9;

   localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [3:0]         op_q, op_d;
   logic [31:0]        a_q, a_d, b_q, b_d;
   logic [31:0]        hi_q, hi_d, lo_q, lo_d;

   function automatic logic is_long(input logic [3:0] code);
      return (code >= OP_MULT) && (code <= OP_MSUB);
   endfunction

   function automatic logic is_div(input logic [3:0] code);
      return (code == OP_DIV) || (code == OP_DIVU);
   endfunction

   // New {hi,lo} for a long op, evaluated on latched operands at the commit edge.
   function automatic logic [63:0] commit_val(input logic [3:0] code, input logic [31:0] x,
                                              input logic [31:0] y, input logic [63:0] acc);
      logic signed [63:0] sprod;
      logic        [63:0] uprod;
      logic signed [31:0] sx, sy, sq, sr;
      sprod = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
      uprod = {32'd0, x} * {32'd0, y};
      sx = $signed(x);
      sy = $signed(y);
      sq = '0;
      sr = '0;
      case (code)
         OP_MULT:  return sprod;
         OP_MULTU: return uprod;
         OP_MADD:  return acc + sprod;
         OP_MADDU: return acc + uprod;
         OP_MSUB:  return acc - sprod;
         OP_DIV: begin
            if (y == 32'd0) return acc;
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
               sq = sx;
               sr = '0;
            end else begin
               sq = sx / sy;
               sr = sx % sy;
            end
            return {sr, sq};
         end
         OP_DIVU: begin
            if (y == 32'd0) return acc;
            return {x % y, x / y};
         end
         default:  return acc;
      endcase
   endfunction

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         S_IDLE: begin
            if (start && !flush) begin
               if (op == OP_SETHI) begin
                  hi_d = a;
               end else if (op == OP_SETLO) begin
                  lo_d = a;
               end else if (is_long(op)) begin
                  op_d    = op;
                  a_d     = a;
                  b_d     = b;
                  cnt_d   = is_div(op) ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
                  state_d = S_BUSY;
               end
            end
         end
         default: begin
            if (flush) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end else if (cnt_q == '0) begin
               {hi_d, lo_d} = commit_val(op_q, a_q, b_q, {hi_q, lo_q});
               state_d      = S_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   // Operand latches are pure data and need no reset.
   always_ff @(posedge clk) begin
      op_q <= op_d;
      a_q  <= a_d;
      b_q  <= b_d;
   end

   assign busy      = (state_q == S_BUSY);
   assign stall_req = busy | (reset & start & is_long(op) & (state_q == S_IDLE) & !flush);
   assign hi        = hi_q;
   assign lo        = lo_q;
   assign result    = out_sel ? hi_q : lo_q;

   logic unused_ok;
   assign unused_ok = ^{OP_DISABLED};

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized bench for muldiv_sequencer against an arithmetic HI/LO reference model.
module tb_muldiv_sequencer;

   localparam int MULC = 5;
   localparam int DIVC = 10;

   localparam logic [3:0] OP_DISABLED = 4'd0;
   localparam logic [3:0] OP_MULT     = 4'd1;
   localparam logic [3:0] OP_MULTU    = 4'd2;
   localparam logic [3:0] OP_DIV      = 4'd3;
   localparam logic [3:0] OP_DIVU     = 4'd4;
   localparam logic [3:0] OP_MADD     = 4'd5;
   localparam logic [3:0] OP_MADDU    = 4'd6;
   localparam logic [3:0] OP_MSUB     = 4'd7;
   localparam logic [3:0] OP_SETHI    = 4'd8;
   localparam logic [3:0] OP_SETLO    = 4'd9;

   logic        clk = 1'b0;
   logic        reset, start, flush, out_sel;
   logic [3:0]  op;
   logic [31:0] a, b;
   logic        busy, stall_req;
   logic [31:0] hi, lo, result;

   int checks = 0;
   int errors = 0;
   logic [31:0] mhi, mlo;

   muldiv_sequencer #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .flush(flush), .out_sel(out_sel), .busy(busy), .stall_req(stall_req),
      .hi(hi), .lo(lo), .result(result)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic bit op_long(input logic [3:0] c);
      return c inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MADDU, OP_MSUB};
   endfunction

   // Reference: architectural effect of one accepted op on HI/LO.
   task automatic model_apply(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
      longint          sx, sy, q, r;
      longint unsigned acc, sp, up;
      sx  = $signed(x);
      sy  = $signed(y);
      sp  = sx * sy;
      up  = longint'(x) * longint'(y);
      acc = {mhi, mlo};
      case (c)
         OP_MULT:  {mhi, mlo} = sp;
         OP_MULTU: {mhi, mlo} = up;
         OP_MADD:  {mhi, mlo} = acc + sp;
         OP_MADDU: {mhi, mlo} = acc + up;
         OP_MSUB:  {mhi, mlo} = acc - sp;
         OP_DIV: if (y != 0) begin
            q = sx / sy;
            r = sx % sy;
            mlo = q[31:0];
            mhi = r[31:0];
         end
         OP_DIVU: if (y != 0) begin
            mlo = x / y;
            mhi = x % y;
         end
         OP_SETHI: mhi = x;
         OP_SETLO: mlo = x;
         default: ;
      endcase
   endtask

   // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
   task automatic run_op(input string tag, input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
      int n;
      start = 1'b1; op = c; a = x; b = y;
      #1;
      check_eq({tag, ".stall"}, stall_req, op_long(c));
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      if (op_long(c)) begin
         n = 0;
         while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
         end
         check_eq({tag, ".lat"}, n, ((c == OP_DIV) || (c == OP_DIVU)) ? DIVC : MULC);
      end else begin
         check_eq({tag, ".busy"}, busy, 1'b0);
      end
      model_apply(c, x, y);
      check_eq({tag, ".hi"}, hi, mhi);
      check_eq({tag, ".lo"}, lo, mlo);
      out_sel = 1'b1; #1;
      check_eq({tag, ".res_hi"}, result, mhi);
      out_sel = 1'b0; #1;
      check_eq({tag, ".res_lo"}, result, mlo);
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         n++;
         @(negedge clk);
      end
      check_eq({tag, ".idle"}, busy, 1'b0);
   endtask

   initial begin
      reset = 1'b0; start = 1'b1; op = OP_MULT; a = 32'd5; b = 32'd5;
      flush = 1'b0; out_sel = 1'b0;
      mhi = '0; mlo = '0;
      @(negedge clk);
      @(negedge clk);
      check_eq("rst.hi", hi, 32'd0);
      check_eq("rst.lo", lo, 32'd0);
      check_eq("rst.busy", busy, 1'b0);
      check_eq("rst.stall", stall_req, 1'b0);
      start = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      check_eq("rel.busy", busy, 1'b0);
      check_eq("rel.hi", hi, 32'd0);

      run_op("mult", OP_MULT, 32'hFFFF_FFFF, 32'd2);
      check_eq("mult.hi_k", hi, 32'hFFFF_FFFF);
      check_eq("mult.lo_k", lo, 32'hFFFF_FFFE);
      run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2);
      check_eq("multu.hi_k", hi, 32'd1);
      run_op("div", OP_DIV, -32'sd7, 32'd2);
      check_eq("div.lo_k", lo, 32'hFFFF_FFFD);
      check_eq("div.hi_k", hi, 32'hFFFF_FFFF);
      run_op("divu", OP_DIVU, 32'd7, 32'd2);
      check_eq("divu.lo_k", lo, 32'd3);
      run_op("div0", OP_DIV, 32'd99, 32'd0);
      check_eq("div0.lo_k", lo, 32'd3);
      run_op("divovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      check_eq("divovf.lo_k", lo, 32'h8000_0000);
      check_eq("divovf.hi_k", hi, 32'd0);
      run_op("mthi", OP_SETHI, 32'h1234, 32'd0);
      check_eq("mthi.hi_k", hi, 32'h1234);
      run_op("mtlo", OP_SETLO, 32'hFFFF_FFFF, 32'd0);
      run_op("mthi0", OP_SETHI, 32'd0, 32'd0);
      run_op("madd", OP_MADD, 32'd1, 32'd1);
      check_eq("madd.hi_k", hi, 32'd1);
      check_eq("madd.lo_k", lo, 32'd0);
      run_op("msub", OP_MSUB, 32'd1, 32'd1);
      check_eq("msub.hi_k", hi, 32'd0);
      check_eq("msub.lo_k", lo, 32'hFFFF_FFFF);

      // Flush in the third busy cycle cancels the commit.
      start = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd3;
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      @(negedge clk); @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check_eq("flush.busy", busy, 1'b0);
      repeat (8) @(negedge clk);
      check_eq("flush.hi", hi, mhi);
      check_eq("flush.lo", lo, mlo);

      // mtlo presented while busy is dropped.
      start = 1'b1; op = OP_DIVU; a = 32'd50; b = 32'd0;
      @(posedge clk); @(negedge clk);
      op = OP_SETLO; a = 32'hDEAD_BEEF;
      #1;
      check_eq("bsy.stall", stall_req, 1'b1);
      @(negedge clk);
      start = 1'b0;
      wait_idle("bsy");
      check_eq("bsy.lo", lo, mlo);
      check_eq("bsy.hi", hi, mhi);

      // start+flush in idle has no effect, even for mthi.
      start = 1'b1; flush = 1'b1; op = OP_SETHI; a = 32'hABCD;
      #1;
      check_eq("sflush.stall", stall_req, 1'b0);
      @(negedge clk);
      op = OP_MULT;
      #1;
      check_eq("sflush.stall2", stall_req, 1'b0);
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      check_eq("sflush.busy", busy, 1'b0);
      check_eq("sflush.hi", hi, mhi);

      // Reset in the fourth busy cycle of a divide.
      start = 1'b1; op = OP_DIV; a = 32'd100; b = 32'd7;
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      check_eq("mrst.busy", busy, 1'b0);
      check_eq("mrst.hi", hi, 32'd0);
      check_eq("mrst.lo", lo, 32'd0);
      mhi = '0; mlo = '0;
      repeat (12) @(negedge clk);
      check_eq("mrst.late_hi", hi, 32'd0);
      check_eq("mrst.late_lo", lo, 32'd0);

      for (int i = 0; i < 60; i++) begin
         logic [3:0]  rc;
         logic [31:0] ra, rb;
         rc = 4'($urandom_range(0, 15));
         ra = $urandom;
         case ($urandom_range(0, 3))
            0: rb = 32'd0;
            1: rb = 32'($urandom_range(1, 9)) * (($urandom & 1) ? 32'd1 : 32'hFFFF_FFFF);
            default: rb = $urandom;
         endcase
         run_op($sformatf("rnd%0d", i), rc, ra, rb);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
